// File: rtl/fir_pkg.sv
// Shared types and constants for the multi-cycle FIR frame sequencer.
// Contents:
//   seq_state_e        sequencer FSM state encoding (IDLE=0, RUN=1, DRAIN=2)
//   RES_CAPTURE_CYCLE  frame cycle at which section results are registered
//   SUM_STAGES         registered adder stages between capture and output
//   clog2()            ceiling log2 for elaboration-time width math
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } seq_state_e;

  // Sections publish the previous frame's result at cycle 2; sample it one cycle later.
  localparam int unsigned RES_CAPTURE_CYCLE = 3;
  localparam int unsigned SUM_STAGES = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_result_adder.sv
// Result combiner: captures the NSEC section results, sums them in one registered stage,
// saturates to OUT_DW bits and holds the sample on a valid/ready output.
// Ports:
//   clk_sample  in   sample-domain clock
//   reset_n     in   async active-low reset
//   capture_en  in   register sec_result this clock (one pulse per primed frame)
//   sec_result  in   NSEC x (OUT_DW+1) signed section results, section 0 in LSBs
//   m_ready     in   downstream accept
//   m_valid     out  output sample valid, held until m_ready
//   m_data      out  saturated sum
//   sat_flag    out  sticky: some emitted sample clipped
module fir_result_adder
  import fir_pkg::*;
#(
  parameter int unsigned OUT_DW = 32,
  parameter int unsigned NSEC   = 4
) (
  input  logic                       clk_sample,
  input  logic                       reset_n,
  input  logic                       capture_en,
  input  logic [NSEC*(OUT_DW+1)-1:0] sec_result,
  input  logic                       m_ready,
  output logic                       m_valid,
  output logic [OUT_DW-1:0]          m_data,
  output logic                       sat_flag
);

  localparam int unsigned ResW = OUT_DW + 1;
  localparam int unsigned SumW = ResW + clog2(NSEC);
  localparam int unsigned PadW = SumW - OUT_DW + 1;

  logic [NSEC*ResW-1:0]   cap_q;
  logic                   cap_valid_q;
  logic                   m_valid_q;
  logic [OUT_DW-1:0]      m_data_q;
  logic                   sat_flag_q;

  logic signed [SumW-1:0] sum;
  logic signed [SumW-1:0] sat_max;
  logic signed [SumW-1:0] sat_min;
  logic [OUT_DW-1:0]      sat_data;
  logic                   clipped;

  assign sat_max = {{PadW{1'b0}}, {(OUT_DW-1){1'b1}}};
  assign sat_min = {{PadW{1'b1}}, {(OUT_DW-1){1'b0}}};

  // Sum is wide enough that no NSEC-way addition can wrap before saturation.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NSEC; i++) begin
      sum = sum + SumW'($signed(cap_q[i*ResW +: ResW]));
    end
  end

  always_comb begin
    sat_data = sum[OUT_DW-1:0];
    clipped  = 1'b0;
    if (sum > sat_max) begin
      sat_data = sat_max[OUT_DW-1:0];
      clipped  = 1'b1;
    end else if (sum < sat_min) begin
      sat_data = sat_min[OUT_DW-1:0];
      clipped  = 1'b1;
    end
  end

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      cap_valid_q <= capture_en;
      if (capture_en) cap_q <= sec_result;
      // The sequencer never starts a frame over an unconsumed sample, so a new sum
      // only arrives when the output slot is already empty.
      if (cap_valid_q) begin
        m_valid_q <= 1'b1;
        m_data_q  <= sat_data;
        if (clipped) sat_flag_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign sat_flag = sat_flag_q;

endmodule

// File: rtl/fir_mc_sequencer.sv
// Frame sequencer for a chain of NSEC multi-cycle FIR sections. Accepts one input sample
// per frame, drives the shared cycle/ce to the sections, loops the chain tail back, and
// hands the summed result to the combiner. Outputs lag inputs by one sample.
// Ports:
//   clk_sample, reset_n       clock, async active-low reset
//   s_valid/s_ready/s_data    input sample handshake
//   ce, cycle, total_cycles   section control (frame runs cycle 0..total_cycles)
//   f_head, b_tail            sample into section 0 f_prev / looped tail into last b_next
//   f_last                    f_next of the last section
//   sec_result                concatenated section results, section 0 in LSBs
//   m_valid/m_ready/m_data    output sample handshake
//   sat_flag                  sticky saturation indicator
module fir_mc_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned OUT_DW = 32,
  parameter int unsigned LGN    = 3,
  parameter int unsigned NSEC   = 4
) (
  input  logic                       clk_sample,
  input  logic                       reset_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DW-1:0]              s_data,
  output logic                       ce,
  output logic [15:0]                cycle,
  output logic [15:0]                total_cycles,
  output logic [DW-1:0]              f_head,
  output logic [DW-1:0]              b_tail,
  input  logic [DW-1:0]              f_last,
  input  logic [NSEC*(OUT_DW+1)-1:0] sec_result,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_DW-1:0]          m_data,
  output logic                       sat_flag
);

  localparam logic [15:0] TotalCycles  = 16'((1 << LGN) + 1);
  localparam logic [15:0] CaptureCycle = 16'(RES_CAPTURE_CYCLE);

  seq_state_e    state_q;
  logic [15:0]   cycle_q;
  logic [DW-1:0] f_head_q;
  logic [DW-1:0] b_tail_q;
  logic          primed_q;
  logic          started_q;

  logic          slot_free;
  logic          at_end;
  logic          capture_en;

  assign slot_free = !m_valid || m_ready;
  assign at_end    = (state_q == StRun) && (cycle_q == TotalCycles);

  // started_q keeps s_ready low until the first edge after reset release.
  always_comb begin
    s_ready = 1'b0;
    if (state_q == StIdle) s_ready = started_q;
    else if (at_end)       s_ready = slot_free;
  end

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cycle_q   <= '0;
      f_head_q  <= '0;
      b_tail_q  <= '0;
      primed_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (s_valid && started_q) begin
            f_head_q <= s_data;
            cycle_q  <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (cycle_q == 16'd0) b_tail_q <= f_last;
          // The first frame after reset only fills the sections; its result is junk.
          if (cycle_q == CaptureCycle) primed_q <= 1'b1;
          if (cycle_q != TotalCycles) begin
            cycle_q <= cycle_q + 16'd1;
          end else if (slot_free) begin
            cycle_q <= '0;
            if (s_valid) f_head_q <= s_data;
            else         state_q  <= StIdle;
          end else begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // s_ready is low here, so the freed slot can only lead back to IDLE.
          if (m_ready) begin
            cycle_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign capture_en = (state_q == StRun) && (cycle_q == CaptureCycle) && primed_q;

  fir_result_adder #(
    .OUT_DW (OUT_DW),
    .NSEC   (NSEC)
  ) u_result_adder (
    .clk_sample (clk_sample),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .sec_result (sec_result),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .sat_flag   (sat_flag)
  );

  assign ce           = (state_q == StRun);
  assign cycle        = cycle_q;
  assign total_cycles = TotalCycles;
  assign f_head       = f_head_q;
  assign b_tail       = b_tail_q;

endmodule

// File: tb/tb_fir_mc_sequencer.sv
// Directed bench for fir_mc_sequencer: reset, priming, handshake, stall/drain,
// back-to-back frames, saturation and mid-frame reset, with sections modelled by
// directly driven sec_result values.
module tb_fir_mc_sequencer;
  localparam int unsigned DW     = 16;
  localparam int unsigned OUT_DW = 32;
  localparam int unsigned LGN    = 3;
  localparam int unsigned NSEC   = 4;
  localparam int unsigned RW     = OUT_DW + 1;

  logic                 clk_sample = 1'b0;
  logic                 reset_n;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 ce;
  logic [15:0]          cycle;
  logic [15:0]          total_cycles;
  logic [DW-1:0]        f_head;
  logic [DW-1:0]        b_tail;
  logic [DW-1:0]        f_last;
  logic [NSEC*RW-1:0]   sec_result;
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_DW-1:0]    m_data;
  logic                 sat_flag;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_sample = ~clk_sample;

  fir_mc_sequencer #(
    .DW     (DW),
    .OUT_DW (OUT_DW),
    .LGN    (LGN),
    .NSEC   (NSEC)
  ) dut (
    .clk_sample   (clk_sample),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ce           (ce),
    .cycle        (cycle),
    .total_cycles (total_cycles),
    .f_head       (f_head),
    .b_tail       (b_tail),
    .f_last       (f_last),
    .sec_result   (sec_result),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .sat_flag     (sat_flag)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic goto_cycle(input int unsigned c);
    for (int i = 0; i < 40; i++) begin
      if (ce && cycle == 16'(c)) break;
      step();
    end
    check_eq("reach_cycle", 64'({ce, cycle}), 64'({1'b1, 16'(c)}));
  endtask

  task automatic set_res(input logic signed [RW-1:0] r0, input logic signed [RW-1:0] r1,
                         input logic signed [RW-1:0] r2, input logic signed [RW-1:0] r3);
    sec_result = {r3, r2, r1, r0};
  endtask

  localparam logic signed [RW-1:0] PosMax = 33'sh0_7FFF_FFFF;
  localparam logic signed [RW-1:0] NegMin = 33'sh1_0000_0000;

  int unsigned ce_drops;
  int unsigned pulses;
  int unsigned accepts;
  int unsigned bad;

  initial begin
    reset_n    = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    f_last     = '0;
    sec_result = '0;
    m_ready    = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_ce", 64'(ce), 64'(0));
    check_eq("rst_cycle", 64'(cycle), 64'(0));
    check_eq("rst_m_valid", 64'(m_valid), 64'(0));
    check_eq("rst_m_data", 64'(m_data), 64'(0));
    check_eq("rst_sat", 64'(sat_flag), 64'(0));
    check_eq("rst_s_ready", 64'(s_ready), 64'(0));
    check_eq("rst_f_head", 64'(f_head), 64'(0));
    check_eq("rst_b_tail", 64'(b_tail), 64'(0));
    check_eq("total_cycles", 64'(total_cycles), 64'(9));
    reset_n = 1'b1;
    #1;
    check_eq("s_ready_pre_edge", 64'(s_ready), 64'(0));
    step();
    check_eq("s_ready_post_edge", 64'(s_ready), 64'(1));

    // Frame 1: unprimed, emits nothing
    s_valid = 1'b1;
    s_data  = 16'd100;
    f_last  = 16'h0007;
    set_res(33'sd999, 33'sd1, 33'sd1, 33'sd1);
    step();
    s_valid = 1'b0;
    check_eq("f1_cycle0", 64'({ce, cycle}), 64'({1'b1, 16'd0}));
    check_eq("f1_f_head", 64'(f_head), 64'(100));
    check_eq("f1_s_ready_mid", 64'(s_ready), 64'(0));
    step();
    check_eq("f1_b_tail", 64'(b_tail), 64'(7));
    goto_cycle(5);
    check_eq("f1_unprimed", 64'(m_valid), 64'(0));
    goto_cycle(9);
    check_eq("f1_end_s_ready", 64'(s_ready), 64'(1));
    step();
    check_eq("f1_idle_ce", 64'({ce, cycle}), 64'(0));

    // Frame 2: first output, then backpressure into DRAIN
    s_valid = 1'b1;
    s_data  = 16'd3;
    set_res(33'sd200, 33'sd0, 33'sd0, 33'sd0);
    step();
    s_valid = 1'b0;
    goto_cycle(4);
    check_eq("f2_no_valid_c4", 64'(m_valid), 64'(0));
    step();
    check_eq("f2_valid_c5", 64'(m_valid), 64'(1));
    check_eq("f2_data", 64'(m_data), 64'(200));
    goto_cycle(9);
    check_eq("f2_busy_s_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b1;
    s_data  = 16'd55;
    step();
    repeat (30) step();
    check_eq("drain_ce", 64'(ce), 64'(0));
    check_eq("drain_cycle", 64'(cycle), 64'(9));
    check_eq("drain_s_ready", 64'(s_ready), 64'(0));
    check_eq("drain_m_valid", 64'(m_valid), 64'(1));
    check_eq("drain_m_data", 64'(m_data), 64'(200));
    check_eq("drain_f_head", 64'(f_head), 64'(3));
    m_ready = 1'b1;
    step();
    check_eq("drain_consumed", 64'(m_valid), 64'(0));
    check_eq("drain_to_idle", 64'({ce, s_ready}), 64'({1'b0, 1'b1}));
    step();
    check_eq("drain_next_f_head", 64'(f_head), 64'(55));
    check_eq("drain_next_run", 64'({ce, cycle}), 64'({1'b1, 16'd0}));

    // Back-to-back frames: sum -10+20-30+5 = -15
    set_res(-33'sd10, 33'sd20, -33'sd30, 33'sd5);
    ce_drops = 0;
    pulses   = 0;
    accepts  = 0;
    bad      = 0;
    for (int i = 0; i < 30; i++) begin
      if (!ce) ce_drops++;
      if (m_valid) begin
        pulses++;
        if (m_data !== 32'hFFFF_FFF1) bad++;
      end
      if (s_valid && s_ready) accepts++;
      step();
    end
    check_eq("b2b_ce_drops", 64'(ce_drops), 64'(0));
    check_eq("b2b_pulses", 64'(pulses), 64'(3));
    check_eq("b2b_accepts", 64'(accepts), 64'(3));
    check_eq("b2b_bad_data", 64'(bad), 64'(0));

    // Exact positive limit, no clipping: 2^30 + 2^30-1
    set_res(33'sh0_4000_0000, 33'sh0_3FFF_FFFF, 33'sd0, 33'sd0);
    goto_cycle(4);
    check_eq("edge_sat_c4", 64'(sat_flag), 64'(0));
    goto_cycle(5);
    check_eq("edge_data", 64'(m_data), 64'(32'h7FFF_FFFF));
    check_eq("edge_no_sat", 64'(sat_flag), 64'(0));

    // Positive overflow
    set_res(PosMax, PosMax, PosMax, PosMax);
    goto_cycle(9);
    step();
    goto_cycle(5);
    check_eq("satp_data", 64'(m_data), 64'(32'h7FFF_FFFF));
    check_eq("satp_flag", 64'(sat_flag), 64'(1));

    // Negative overflow
    set_res(NegMin, NegMin, NegMin, NegMin);
    goto_cycle(9);
    step();
    goto_cycle(5);
    check_eq("satn_data", 64'(m_data), 64'(32'h8000_0000));

    // In-range after clipping; flag stays set
    set_res(33'sd1, 33'sd2, 33'sd3, 33'sd4);
    goto_cycle(9);
    step();
    goto_cycle(5);
    check_eq("sticky_data", 64'(m_data), 64'(10));
    check_eq("sticky_flag", 64'(sat_flag), 64'(1));

    // m_ready arriving in the decision cycle
    m_ready = 1'b0;
    goto_cycle(9);
    check_eq("simul_busy", 64'(s_ready), 64'(0));
    m_ready = 1'b1;
    s_data  = 16'd77;
    #1;
    check_eq("simul_s_ready", 64'(s_ready), 64'(1));
    step();
    check_eq("simul_run", 64'({ce, cycle}), 64'({1'b1, 16'd0}));
    check_eq("simul_f_head", 64'(f_head), 64'(77));
    check_eq("simul_consumed", 64'(m_valid), 64'(0));
    s_valid = 1'b0;
    step();
    check_eq("simul_no_drain", 64'({ce, cycle}), 64'({1'b1, 16'd1}));

    // Mid-frame reset at cycle 4
    goto_cycle(4);
    reset_n = 1'b0;
    #1;
    check_eq("mrst_ce", 64'(ce), 64'(0));
    check_eq("mrst_cycle", 64'(cycle), 64'(0));
    check_eq("mrst_m_data", 64'(m_data), 64'(0));
    check_eq("mrst_sat", 64'(sat_flag), 64'(0));
    check_eq("mrst_f_head", 64'(f_head), 64'(0));
    check_eq("mrst_s_ready", 64'(s_ready), 64'(0));
    step();
    reset_n = 1'b1;
    step();
    check_eq("mrst_s_ready_after", 64'(s_ready), 64'(1));

    // First frame after reset is unprimed again
    s_valid = 1'b1;
    s_data  = 16'd9;
    set_res(33'sd5, 33'sd5, 33'sd5, 33'sd5);
    step();
    s_valid = 1'b0;
    goto_cycle(5);
    check_eq("mrst_unprimed", 64'(m_valid), 64'(0));
    goto_cycle(9);
    step();
    check_eq("mrst_idle", 64'(ce), 64'(0));
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    goto_cycle(5);
    check_eq("mrst_primed_valid", 64'(m_valid), 64'(1));
    check_eq("mrst_primed_data", 64'(m_data), 64'(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
